// File: rtl/sbuf_ctrl_pkg.sv
// Shared types and constants for the systolic output buffer sequencer.
// The optional watchdog is enabled with SBUF_CTRL_WATCHDOG_EN.
package sbuf_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StRun,
      StDrain,
      StDone
   } state_e;

   localparam int unsigned ADR_W       = 9;
   localparam int unsigned SA_BANK_BIT = 8;
   localparam int unsigned WD_W        = 12;
   localparam int unsigned WD_LIMIT    = 4095;

   // One packed saturation word covers 16 result words.
   function automatic logic [ADR_W-1:0] calc_nsa(input logic [ADR_W-1:0] len);
      logic [ADR_W-1:0] w_sum;
      w_sum = len + ADR_W'(15);
      return {4'b0000, w_sum[ADR_W-1:4]};
   endfunction

endpackage

// File: rtl/sbuf_ctrl_skid2.sv
// Two-entry valid/ready skid FIFO with fall-through when empty.
// Occupancy is exported so the producer can issue reads only against free slots.
module sbuf_ctrl_skid2 #(
   parameter int unsigned W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_occ
);
   import sbuf_ctrl_pkg::*;

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_occ;

   logic         w_empty;
   logic         w_bypass;
   logic         w_push;
   logic         w_pop;

   assign w_empty  = (r_occ == 2'd0);
   // An arriving word consumed in the same cycle never touches storage.
   assign w_bypass = w_empty & i_valid & i_ready;
   assign w_push   = i_valid & ~w_bypass;
   assign w_pop    = ~w_empty & i_ready;

   assign o_valid = ~w_empty | i_valid;
   assign o_data  = ~w_empty ? r_mem[r_rd_ptr] : (i_valid ? i_data : '0);
   assign o_occ   = r_occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/sbuf_ctrl.sv
// Output buffer sequencer: start/run/finish handshake, result drain stream and
// read-port arbitration against CPU reads. Watchdog enabled by SBUF_CTRL_WATCHDOG_EN.
module sbuf_ctrl #(
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_go,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_drain,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              sb_start,
   output logic [LEN_W-1:0]  sb_run_cntr,
   input  logic              sb_finish,
   input  logic              cpu_rreq,
   input  logic [8:0]        cpu_radr,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_stall,
   output logic [8:0]        sb_radr,
   input  logic [DATA_W-1:0] sb_rdata,
   output logic [DATA_W-1:0] dr_data,
   output logic              dr_valid,
   input  logic              dr_ready,
   output logic              dr_last
);
   import sbuf_ctrl_pkg::*;

   localparam int unsigned ST_W = $clog2(STARVE_MAX + 2);

   state_e             r_state;
   logic [LEN_W-1:0]   r_len;
   logic               r_drain;
   logic               r_sb_start;
   logic               r_done;
   logic [ADR_W-1:0]   r_total;
   logic [ADR_W-1:0]   r_rd_cnt;
   logic [ST_W-1:0]    r_starve;
   logic               r_pend_dr;
   logic               r_pend_last;
   logic               r_cpu_pend;

   logic               w_accept;
   logic               w_wd_expire;
   logic [ADR_W-1:0]   w_len_adr;
   logic [ADR_W-1:0]   w_sat_idx;
   logic [ADR_W-1:0]   w_dr_addr;
   logic               w_dr_want;
   logic [2:0]         w_inuse;
   logic               w_credit;
   logic               w_dr_can;
   logic               w_starved;
   logic               w_gnt_dr;
   logic               w_gnt_cpu;
   logic               w_last_issue;
   logic               w_last_acc;
   logic [1:0]         w_occ;
   logic [DATA_W:0]    w_sk_data;

   assign w_accept = (r_state == StIdle) & cmd_go;

   // ---------------------------------------------------------------- sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_len      <= '0;
         r_drain    <= 1'b0;
         r_sb_start <= 1'b0;
         r_done     <= 1'b0;
         r_total    <= '0;
      end else begin
         r_sb_start <= 1'b0;
         r_done     <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (cmd_go) begin
                  r_len   <= cmd_len;
                  r_drain <= cmd_drain;
                  r_total <= ADR_W'(cmd_len) + calc_nsa(ADR_W'(cmd_len));
                  if (cmd_len != '0) begin
                     r_state    <= StStart;
                     r_sb_start <= 1'b1;
                  end else begin
                     r_state <= StDone;
                  end
               end
            end
            StStart: r_state <= StRun;
            StRun: begin
               if (sb_finish) begin
                  r_state <= r_drain ? StDrain : StDone;
               end else if (w_wd_expire) begin
                  r_state <= StDone;
               end
            end
            StDrain: begin
               if (w_last_acc) begin
                  r_state <= StDone;
               end
            end
            StDone: begin
               r_done  <= 1'b1;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy        = (r_state != StIdle);
   assign done        = r_done;
   assign sb_start    = r_sb_start;
   assign sb_run_cntr = r_len;

   // ---------------------------------------------------------------- watchdog
`ifdef SBUF_CTRL_WATCHDOG_EN
   logic [WD_W-1:0] r_wd_cnt;
   logic            r_err;

   assign w_wd_expire = (r_state == StRun) & ~sb_finish & (r_wd_cnt == WD_W'(WD_LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         r_wd_cnt <= (r_state == StRun) ? r_wd_cnt + WD_W'(1) : '0;
         if (w_accept) begin
            r_err <= 1'b0;
         end else if (w_wd_expire) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err = r_err;
`else
   assign w_wd_expire = 1'b0;
   assign err         = 1'b0;
`endif

   // ---------------------------------------------------------------- drain address
   assign w_len_adr = ADR_W'(r_len);
   assign w_sat_idx = r_rd_cnt - w_len_adr;

   always_comb begin
      w_dr_addr = r_rd_cnt;
      if (r_rd_cnt >= w_len_adr) begin
         w_dr_addr              = w_sat_idx;
         w_dr_addr[SA_BANK_BIT] = 1'b1;
      end
   end

   assign w_last_issue = (r_rd_cnt == (r_total - ADR_W'(1)));

   // ---------------------------------------------------------------- arbitration
   assign w_dr_want = (r_state == StDrain) & (r_rd_cnt < r_total);
   // Reads in flight are counted so the skid can absorb every returned word.
   assign w_inuse   = {1'b0, w_occ} + {2'b00, r_pend_dr};
   assign w_credit  = (w_inuse < 3'd2);
   assign w_dr_can  = w_dr_want & w_credit;
   assign w_starved = (r_starve >= ST_W'(STARVE_MAX));
   assign w_gnt_dr  = w_dr_can & (~cpu_rreq | w_starved);
   assign w_gnt_cpu = cpu_rreq & ~w_gnt_dr;

   assign cpu_stall = cpu_rreq & w_gnt_dr;
   assign sb_radr   = w_gnt_dr ? w_dr_addr : (cpu_rreq ? cpu_radr : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_cnt    <= '0;
         r_starve    <= '0;
         r_pend_dr   <= 1'b0;
         r_pend_last <= 1'b0;
         r_cpu_pend  <= 1'b0;
      end else begin
         r_pend_dr   <= w_gnt_dr;
         r_pend_last <= w_gnt_dr & w_last_issue;
         r_cpu_pend  <= w_gnt_cpu;
         if (r_state != StDrain) begin
            r_rd_cnt <= '0;
         end else if (w_gnt_dr) begin
            r_rd_cnt <= r_rd_cnt + ADR_W'(1);
         end
         if ((r_state != StDrain) || w_gnt_dr) begin
            r_starve <= '0;
         end else if (cpu_rreq && w_dr_can && !w_starved) begin
            r_starve <= r_starve + ST_W'(1);
         end
      end
   end

   assign cpu_rvalid = r_cpu_pend;
   assign cpu_rdata  = r_cpu_pend ? sb_rdata : '0;

   // ---------------------------------------------------------------- drain stream
   sbuf_ctrl_skid2 #(
      .W(DATA_W + 1)
   ) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_valid(r_pend_dr),
      .i_data ({r_pend_last, sb_rdata}),
      .i_ready(dr_ready),
      .o_valid(dr_valid),
      .o_data (w_sk_data),
      .o_occ  (w_occ)
   );

   assign dr_data    = w_sk_data[DATA_W-1:0];
   assign dr_last    = w_sk_data[DATA_W];
   assign w_last_acc = dr_valid & dr_ready & dr_last;

endmodule
